u_mult8: RTL and testbench

- 8x8 unsigned integer multiplier for the Troy WideWord Processor ALU datapath.
- Forms the 16-bit product of two 8-bit unsigned operands using a partial-product array (shift-and-add), then registers the result.
- Used as the byte-lane building block for the ALU's wider unsigned multiply operations.

---
 rtl/u_mult8_if.sv | 32 +++
 rtl/u_mult8.sv | 76 +++++++
 tb/tb_u_mult8.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/u_mult8_if.sv
// u_mult8_if: operand/result bundle for the 8x8 unsigned multiplier.
// All buses are big-endian indexed (index 0 = MSB); numeric values are
// plain unsigned binary.
//   reg_A     [0:7]   multiplicand
//   reg_B     [0:7]   multiplier
//   in_valid          operands valid this cycle
//   result    [0:15]  registered product
//   out_valid         result carries the product of the last valid operands
// master: operand source / result consumer; slave: the multiplier.
interface u_mult8_if;
    logic [0:7]  reg_A;
    logic [0:7]  reg_B;
    logic        in_valid;
    logic [0:15] result;
    logic        out_valid;

    modport master (
        output reg_A,
        output reg_B,
        output in_valid,
        input  result,
        input  out_valid
    );

    modport slave (
        input  reg_A,
        input  reg_B,
        input  in_valid,
        output result,
        output out_valid
    );
endinterface

// File: rtl/u_mult8.sv
// u_mult8: 8x8 unsigned multiplier, shift-and-add partial-product array,
// one-cycle registered latency, full throughput.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (result = 0, out_valid = 0)
//   bus   u_mult8_if.slave: reg_A/reg_B/in_valid in, result/out_valid out
module u_mult8 (
    input  logic       clk,
    input  logic       rst,
    u_mult8_if.slave   bus
);

    // Partial product of weight 2^shift: multiplicand gated by one multiplier
    // bit, zero-extended to the product width and shifted into place.
    function automatic logic [15:0] partial_product(
        input logic [7:0] a,
        input logic       b_bit,
        input int unsigned shift
    );
        logic [15:0] ext;
        ext = {8'h00, (a & {8{b_bit}})};
        return ext << shift;
    endfunction

    // Operands re-viewed with conventional [7:0] numbering so that
    // index i carries weight 2^i (reg_X[7] is the LSB of the bus).
    logic [7:0]  a_s;
    logic [7:0]  b_s;
    logic [15:0] sum_s;

    logic [15:0] result_d;
    logic [15:0] result_q;
    logic        out_valid_d;
    logic        out_valid_q;

    assign a_s = bus.reg_A;
    assign b_s = bus.reg_B;

    // Ripple accumulation of the eight partial products.
    always_comb begin
        sum_s = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            sum_s = sum_s + partial_product(a_s, b_s[i], i);
        end
    end

    // Next-state: load the product on a valid cycle, otherwise hold result
    // and drop out_valid.
    always_comb begin
        result_d    = result_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            result_d    = sum_s;
            out_valid_d = 1'b1;
        end else begin
            result_d    = result_q;
            out_valid_d = 1'b0;
        end
    end

    // Output registers; reset clears both immediately and masks in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= 16'h0000;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    // The [15:0] register maps value-preservingly onto the [0:15] bus.
    assign bus.result    = result_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_u_mult8.sv
module tb_u_mult8;

    logic clk;
    logic rst;
    u_mult8_if bus ();

    u_mult8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    int          n_cmp;
    int          n_fail;
    logic [15:0] exp_res;
    logic        exp_vld;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, then update the reference model
    // and sample just after the rising edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic v);
        @(negedge clk);
        bus.reg_A    = a;
        bus.reg_B    = b;
        bus.in_valid = v;
        @(posedge clk);
        #1;
        if (v) begin
            exp_res = 16'(int'(a) * int'(b));
            exp_vld = 1'b1;
        end else begin
            exp_vld = 1'b0;
        end
    endtask

    task automatic check_model(input string name);
        check({name, "_result"}, bus.result, exp_res);
        check({name, "_valid"}, {15'h0000, bus.out_valid}, {15'h0000, exp_vld});
    endtask

    vec_t tbl [7];

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        exp_res = 16'h0000;
        exp_vld = 1'b0;

        tbl[0] = '{8'h03, 8'h02, 16'h0006};
        tbl[1] = '{8'hFF, 8'hFF, 16'hFE01};
        tbl[2] = '{8'h00, 8'hA5, 16'h0000};
        tbl[3] = '{8'h01, 8'h80, 16'h0080};
        tbl[4] = '{8'h10, 8'h10, 16'h0100};
        tbl[5] = '{8'h0F, 8'h11, 16'h00FF};
        tbl[6] = '{8'hC8, 8'h05, 16'h03E8};

        rst          = 1'b1;
        bus.reg_A    = 8'h00;
        bus.reg_B    = 8'h00;
        bus.in_valid = 1'b0;
        #1;
        check("reset_result", bus.result, 16'h0000);
        check("reset_valid", {15'h0000, bus.out_valid}, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors back-to-back: full throughput, out_valid stays high.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].a, tbl[i].b, 1'b1);
            check($sformatf("tbl%0d_result", i), bus.result, tbl[i].p);
            check($sformatf("tbl%0d_valid", i), {15'h0000, bus.out_valid}, 16'h0001);
        end

        // Basic: product then idle cycle with changed operands -> held.
        step(8'h03, 8'h02, 1'b1);
        check("basic_result", bus.result, 16'h0006);
        step(8'hAA, 8'h55, 1'b0);
        check("basic_hold_result", bus.result, 16'h0006);
        check("basic_hold_valid", {15'h0000, bus.out_valid}, 16'h0000);

        // Bit order: 0x80 * 0x02 sets only result bit index 7.
        step(8'h80, 8'h02, 1'b1);
        check("bitorder_result", bus.result, 16'h0100);
        check("bitorder_bit7", {15'h0000, bus.result[7]}, 16'h0001);
        check("bitorder_bit8", {15'h0000, bus.result[8]}, 16'h0000);

        // Async reset between edges.
        step(8'hFF, 8'hFF, 1'b1);
        check("pre_reset_result", bus.result, 16'hFE01);
        @(negedge clk);
        bus.in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_result", bus.result, 16'h0000);
        check("async_rst_valid", {15'h0000, bus.out_valid}, 16'h0000);
        @(posedge clk);
        #1;
        check("rst_held_result", bus.result, 16'h0000);
        check("rst_held_valid", {15'h0000, bus.out_valid}, 16'h0000);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        exp_res      = 16'h0000;
        exp_vld      = 1'b0;
        step(8'h12, 8'h34, 1'b0);
        check_model("post_rst_idle");
        check("post_rst_idle_zero", bus.result, 16'h0000);
        step(8'h12, 8'h34, 1'b1);
        check("post_rst_first", bus.result, 16'h03A8);

        // Random operands with random in_valid against the reference model.
        for (int i = 0; i < 1000; i++) begin
            step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
            check_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
